inst_fetch_resp: RTL and testbench

Instruction-fetch responder: the memory-side end of the fetch interface driven by the PC unit (pc/ce in; instruction out).
- Accepts one word-aligned fetch address per transaction.
- Runs a single-outstanding request/response handshake to the backing instruction memory, then returns the instruction word to IF/ID with a one-cycle valid pulse.
- Asserts stall_req while a fetch is pending so the PC unit and IF/ID hold.
- Honours branch flush by discarding in-flight responses.

---
 rtl/inst_fetch_resp.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_resp.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: single-outstanding memory fetch, flush-aware, optional FETCH_BUF_EN last-fetch buffer.
// Latency: 3 cycles ce->inst_valid on a miss with immediate gnt/rvalid; 1 cycle on misalign or buffer hit.
// Backpressure: stall_req holds PC and IF/ID while a fetch is pending; memory gnt/rvalid latency is unbounded.
module inst_fetch_resp #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              stall_req,
    output logic [DATA_W-1:0] inst,
    output logic              inst_valid,
    output logic              addr_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state, state_nxt;
    logic              drop_flag, drop_flag_nxt;
    logic [DATA_W-1:0] inst_nxt;
    logic              inst_valid_nxt, addr_err_nxt, mem_req_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic              buffer_hit;
    logic [DATA_W-1:0] buf_data;

    logic              aligned;
    logic [ADDR_W-1:0] word_addr;
    assign aligned   = (pc[1:0] == 2'b00);
    assign word_addr = {pc[ADDR_W-1:2], 2'b00};

`ifdef FETCH_BUF_EN
    logic              buf_vld;
    logic [ADDR_W-1:0] buf_tag;
    logic              buf_fill;

    // Only responses actually handed to IF/ID are cached; flush never invalidates.
    assign buf_fill   = (state == WAIT) && mem_rvalid && !flush;
    assign buffer_hit = buf_vld && (buf_tag == word_addr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld  <= 1'b0;
            buf_tag  <= '0;
            buf_data <= '0;
        end else if (buf_fill) begin
            buf_vld  <= 1'b1;
            buf_tag  <= mem_addr;
            buf_data <= mem_rdata;
        end
    end
`else
    assign buffer_hit = 1'b0;
    assign buf_data   = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            drop_flag  <= 1'b0;
            inst       <= '0;
            inst_valid <= 1'b0;
            addr_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            state      <= state_nxt;
            drop_flag  <= drop_flag_nxt;
            inst       <= inst_nxt;
            inst_valid <= inst_valid_nxt;
            addr_err   <= addr_err_nxt;
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drop_flag_nxt  = drop_flag;
        inst_nxt       = inst;
        inst_valid_nxt = 1'b0;
        addr_err_nxt   = 1'b0;
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        case (state)
            IDLE: begin
                if (ce && !flush) begin
                    if (!aligned) begin
                        addr_err_nxt   = 1'b1;
                        inst_valid_nxt = 1'b1;
                        inst_nxt       = '0;
                    end else if (buffer_hit) begin
                        inst_nxt       = buf_data;
                        inst_valid_nxt = 1'b1;
                    end else begin
                        mem_addr_nxt = word_addr;
                        mem_req_nxt  = 1'b1;
                        state_nxt    = REQ;
                    end
                end
            end
            REQ: begin
                // The request stays up until granted; a flush only marks the response for discard.
                if (flush) drop_flag_nxt = 1'b1;
                if (mem_gnt) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = (flush || drop_flag) ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = IDLE;
                    if (!flush) begin
                        inst_nxt       = mem_rdata;
                        inst_valid_nxt = 1'b1;
                    end
                end else if (flush) begin
                    drop_flag_nxt = 1'b1;
                    state_nxt     = DROP;
                end
            end
            DROP: begin
                if (mem_rvalid) begin
                    drop_flag_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall_req = (state != IDLE) || (ce && !flush && aligned && !buffer_hit);

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Bench for inst_fetch_resp: transaction-level reference model with randomized memory timing and flushes.
module tb_inst_fetch_resp;

`ifdef FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ce, flush, mem_gnt, mem_rvalid;
    logic [31:0] pc, mem_rdata;
    logic        stall_req, inst_valid, addr_err, mem_req;
    logic [31:0] inst, mem_addr;

    inst_fetch_resp #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
        .stall_req(stall_req), .inst(inst), .inst_valid(inst_valid),
        .addr_err(addr_err), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: last delivered instruction and the one-entry fetch buffer.
    logic [31:0] m_inst;
    bit          m_buf_v;
    logic [31:0] m_buf_tag, m_buf_dat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(input logic [31:0] a);
        return BUF_EN && m_buf_v && (m_buf_tag == a);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycle with noise on ignored inputs; pulses must be gone and inst must hold.
    task automatic quiet_cycle();
        ce = 1'b0; flush = 1'b0; pc = $urandom;
        mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
        @(negedge clk);
        check("stall_quiet", 32'(stall_req), 0);
        tick();
        check("iv_quiet", 32'(inst_valid), 0);
        check("aerr_quiet", 32'(addr_err), 0);
        check("req_quiet", 32'(mem_req), 0);
        check("inst_hold", inst, m_inst);
    endtask

    // One fetch: gd cycles before gnt, rd cycles after gnt before rvalid,
    // flush at cycle fl counted from the first REQ cycle (-1 = none).
    task automatic fetch(input logic [31:0] a, input int gd, input int rd,
                         input int fl, input logic [31:0] d);
        bit dropped = 0;
        bit hit;
        ce = 1'b1; pc = a; flush = 1'b0; mem_gnt = 1'b0;
        mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
        if (a[1:0] != 2'b00) begin
            @(negedge clk);
            check("stall_mis", 32'(stall_req), 0);
            tick();
            check("aerr_mis", 32'(addr_err), 1);
            check("iv_mis", 32'(inst_valid), 1);
            check("inst_mis", inst, 0);
            check("req_mis", 32'(mem_req), 0);
            m_inst = 32'h0;
        end else begin
            hit = m_hit(a);
            @(negedge clk);
            check("stall_issue", 32'(stall_req), 32'(!hit));
            tick();
            if (hit) begin
                check("iv_hit", 32'(inst_valid), 1);
                check("inst_hit", inst, m_buf_dat);
                check("req_hit", 32'(mem_req), 0);
                m_inst = m_buf_dat;
            end else begin
                check("req_start", 32'(mem_req), 1);
                check("addr_start", mem_addr, a);
                check("iv_start", 32'(inst_valid), 0);
                for (int k = 0; k <= gd; k++) begin
                    ce = 1'($urandom % 2); pc = $urandom;
                    mem_gnt = (k == gd); mem_rvalid = 1'($urandom % 2); mem_rdata = $urandom;
                    flush = (k == fl);
                    if (flush) dropped = 1;
                    @(negedge clk);
                    check("stall_req_ph", 32'(stall_req), 1);
                    tick();
                    check("req_hold", 32'(mem_req), 32'(k < gd));
                    if (k < gd) check("addr_hold", mem_addr, a);
                    check("iv_req_ph", 32'(inst_valid), 0);
                end
                for (int j = 0; j <= rd; j++) begin
                    ce = 1'($urandom % 2); pc = $urandom;
                    mem_gnt = 1'($urandom % 2); mem_rvalid = (j == rd);
                    mem_rdata = (j == rd) ? d : $urandom;
                    flush = (fl == gd + 1 + j);
                    if (flush) dropped = 1;
                    @(negedge clk);
                    check("stall_wait_ph", 32'(stall_req), 1);
                    tick();
                    if (j < rd) begin
                        check("iv_wait_ph", 32'(inst_valid), 0);
                    end else begin
                        check("iv_resp", 32'(inst_valid), 32'(!dropped));
                        if (!dropped) begin
                            m_inst = d;
                            m_buf_v = 1; m_buf_tag = a; m_buf_dat = d;
                        end
                        check("inst_resp", inst, m_inst);
                    end
                end
            end
        end
        quiet_cycle();
    endtask

    initial begin
        logic [31:0] a;
        int gd, rd, fl;
        rst = 1'b0; ce = 1'b0; flush = 1'b0; pc = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        m_inst = '0; m_buf_v = 0; m_buf_tag = '0; m_buf_dat = '0;
        #12;
        check("rst_inst", inst, 0);
        check("rst_iv", 32'(inst_valid), 0);
        check("rst_aerr", 32'(addr_err), 0);
        check("rst_req", 32'(mem_req), 0);
        check("rst_addr", mem_addr, 0);
        check("rst_stall", 32'(stall_req), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        fetch(32'h0000_0000, 0, 0, -1, 32'h3C01_1234);
        fetch(32'h0000_0004, 4, 5, -1, $urandom);
        fetch(32'h0000_0008, 0, 3, 1, 32'hDEAD_BEEF);
        fetch(32'h0000_0040, 0, 0, -1, $urandom);
        fetch(32'h0000_000C, 3, 1, 1, $urandom);
        fetch(32'h0000_0006, 0, 0, -1, 32'h0);
        fetch(32'h0000_0040, 1, 1, -1, $urandom);
        fetch(32'h0000_0014, 1, 2, 4, $urandom);

        // Flush in IDLE blocks a new fetch even with ce high.
        ce = 1'b1; pc = 32'h0000_0020; flush = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        check("stall_idle_flush", 32'(stall_req), 0);
        tick();
        check("req_idle_flush", 32'(mem_req), 0);
        check("iv_idle_flush", 32'(inst_valid), 0);
        quiet_cycle();

        // Reset while a fetch sits in WAIT; the stale response must be ignored.
        ce = 1'b1; pc = 32'h0000_0010; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        ce = 1'b0; mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_inst", inst, 0);
        check("arst_iv", 32'(inst_valid), 0);
        check("arst_req", 32'(mem_req), 0);
        check("arst_addr", mem_addr, 0);
        check("arst_stall", 32'(stall_req), 0);
        m_inst = '0; m_buf_v = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        tick();
        check("stale_iv", 32'(inst_valid), 0);
        check("stale_inst", inst, 0);
        check("stale_req", 32'(mem_req), 0);
        quiet_cycle();
        fetch(32'h0000_0040, 0, 0, -1, $urandom);
        fetch(32'h0000_0040, 0, 0, -1, $urandom);

        for (int i = 0; i < 60; i++) begin
            a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            fl = ($urandom_range(0, 2) == 0) ? $urandom_range(0, gd + rd + 1) : -1;
            fetch(a, gd, rd, fl, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
